// File: rtl/serial_twos_comp_mc_if.sv
// Bundle of the serial data, framing and status signals of the multi-channel
// bit-serial two's-complement negator. The bit clock and reset stay outside
// the bundle as plain ports.
interface serial_twos_comp_mc_if #(
    parameter int N_CH = 4
);
    logic            in_valid;
    logic            in_sof;
    logic [N_CH-1:0] x;
    logic [N_CH-1:0] neg;
    logic [N_CH-1:0] y;
    logic            out_valid;
    logic            out_sof;
    logic            out_eof;
    logic [N_CH-1:0] ovf;
    logic            framing_err;

    // Source side: drives bits and modes, observes results.
    modport master (
        output in_valid, in_sof, x, neg,
        input  y, out_valid, out_sof, out_eof, ovf, framing_err
    );

    // Negator side: consumes bits and modes, produces results.
    modport slave (
        input  in_valid, in_sof, x, neg,
        output y, out_valid, out_sof, out_eof, ovf, framing_err
    );
endinterface

// File: rtl/serial_twos_comp_mc.sv
// Multi-channel bit-serial two's-complement negator.
// Words are W bits, LSB-first, and all channels share one bit counter and one
// framing. Per channel, bits are copied up to and including the first 1 and
// inverted afterwards when the word's latched mode requests negation.
// Negating the most-negative value is flagged on the last bit of the word.
// An in_sof arriving mid-word aborts the partial word and starts a new one.
module serial_twos_comp_mc #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W)
) (
    input  logic                  t_clock,
    input  logic                  r,
    serial_twos_comp_mc_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    // Word state
    logic [CNT_W-1:0] cnt_r;
    logic [N_CH-1:0]  seen_r;
    logic [N_CH-1:0]  mode_r;

    // Registered outputs
    logic [N_CH-1:0]  y_r;
    logic             out_valid_r;
    logic             out_sof_r;
    logic             out_eof_r;
    logic [N_CH-1:0]  ovf_r;
    logic             framing_err_r;

    // Next-state terms for an accepted bit
    logic             is_bit0_s;
    logic             is_last_s;
    logic             resync_s;
    logic [N_CH-1:0]  mode_eff_s;
    logic [N_CH-1:0]  seen_eff_s;
    logic [N_CH-1:0]  y_nxt_s;
    logic [N_CH-1:0]  ovf_nxt_s;
    logic [N_CH-1:0]  seen_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Decode bit position and compute per-channel results for the current bit.
    always_comb begin
        is_bit0_s  = (cnt_r == CNT_ZERO) || bus.in_sof;
        resync_s   = bus.in_sof && (cnt_r != CNT_ZERO);
        // A resync bit is bit 0 of the new word, never the tail of the old one.
        is_last_s  = (!is_bit0_s) && (cnt_r == CNT_LAST);
        mode_eff_s = mode_r;
        seen_eff_s = seen_r;
        if (is_bit0_s) begin
            mode_eff_s = bus.neg;
            seen_eff_s = {N_CH{1'b0}};
        end else begin
            mode_eff_s = mode_r;
            seen_eff_s = seen_r;
        end
        y_nxt_s    = bus.x ^ (mode_eff_s & seen_eff_s);
        ovf_nxt_s  = {N_CH{1'b0}};
        seen_nxt_s = seen_eff_s | bus.x;
        cnt_nxt_s  = cnt_r + CNT_ONE;
        if (is_last_s) begin
            // Input 100..0 under negation maps onto itself.
            ovf_nxt_s  = mode_eff_s & bus.x & ~seen_eff_s;
            seen_nxt_s = {N_CH{1'b0}};
            cnt_nxt_s  = CNT_ZERO;
        end else if (is_bit0_s) begin
            ovf_nxt_s  = {N_CH{1'b0}};
            seen_nxt_s = bus.x;
            cnt_nxt_s  = CNT_ONE;
        end else begin
            ovf_nxt_s  = {N_CH{1'b0}};
            seen_nxt_s = seen_eff_s | bus.x;
            cnt_nxt_s  = cnt_r + CNT_ONE;
        end
    end

    // Advance word state and register outputs on accepted bits; stalls hold state and y.
    always_ff @(posedge t_clock or negedge r) begin
        if (!r) begin
            cnt_r         <= CNT_ZERO;
            seen_r        <= {N_CH{1'b0}};
            mode_r        <= {N_CH{1'b0}};
            y_r           <= {N_CH{1'b0}};
            out_valid_r   <= 1'b0;
            out_sof_r     <= 1'b0;
            out_eof_r     <= 1'b0;
            ovf_r         <= {N_CH{1'b0}};
            framing_err_r <= 1'b0;
        end else if (bus.in_valid) begin
            cnt_r         <= cnt_nxt_s;
            seen_r        <= seen_nxt_s;
            mode_r        <= mode_eff_s;
            y_r           <= y_nxt_s;
            out_valid_r   <= 1'b1;
            out_sof_r     <= is_bit0_s;
            out_eof_r     <= is_last_s;
            ovf_r         <= ovf_nxt_s;
            framing_err_r <= resync_s;
        end else begin
            out_valid_r   <= 1'b0;
            out_sof_r     <= 1'b0;
            out_eof_r     <= 1'b0;
            ovf_r         <= {N_CH{1'b0}};
            framing_err_r <= 1'b0;
        end
    end

    assign bus.y           = y_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_sof     = out_sof_r;
    assign bus.out_eof     = out_eof_r;
    assign bus.ovf         = ovf_r;
    assign bus.framing_err = framing_err_r;

endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Scoreboard bench for serial_twos_comp_mc: stimulus pushes the expected
// output beat for every accepted bit, and a monitor on the falling edge pops
// and compares whenever the DUT presents out_valid.
module tb_serial_twos_comp_mc;

    localparam int N_CH = 4;
    localparam int W    = 8;

    typedef struct packed {
        logic [N_CH-1:0] y;
        logic            sof;
        logic            eof;
        logic [N_CH-1:0] ovf;
        logic            ferr;
    } beat_t;

    logic  t_clock = 1'b0;
    logic  r       = 1'b0;
    int    total   = 0;
    int    bad     = 0;
    beat_t exp_q[$];

    serial_twos_comp_mc_if #(.N_CH(N_CH)) bus ();

    serial_twos_comp_mc #(.N_CH(N_CH), .W(W)) dut (
        .t_clock (t_clock),
        .r       (r),
        .bus     (bus)
    );

    always #5 t_clock = ~t_clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: every valid output beat must match the oldest expected beat.
    always @(negedge t_clock) begin
        if (bus.out_valid === 1'b1) begin
            beat_t got;
            beat_t e;
            got = '{y: bus.y, sof: bus.out_sof, eof: bus.out_eof, ovf: bus.ovf, ferr: bus.framing_err};
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL beat_unexpected: got y=%h sof=%b eof=%b ovf=%h ferr=%b want no beat",
                         got.y, got.sof, got.eof, got.ovf, got.ferr);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad = bad + 1;
                    $display("FAIL beat: got y=%h sof=%b eof=%b ovf=%h ferr=%b want y=%h sof=%b eof=%b ovf=%h ferr=%b",
                             got.y, got.sof, got.eof, got.ovf, got.ferr,
                             e.y, e.sof, e.eof, e.ovf, e.ferr);
                end
            end
        end
    end

    // Drive one cycle of input; returns 1 time unit after the capturing edge.
    task automatic put(input logic v, input logic sof, input logic [N_CH-1:0] xb, input logic [N_CH-1:0] nb);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.x        = xb;
        bus.neg      = nb;
        @(posedge t_clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) put(1'b0, 1'b0, {N_CH{1'b0}}, {N_CH{1'b0}});
    endtask

    // Send the first nbits of a word on all channels, with optional stall after bit stall_after.
    task automatic send_word(input logic [N_CH-1:0][W-1:0] xw, input logic [N_CH-1:0][W-1:0] ew,
                             input logic [N_CH-1:0] nb, input logic [N_CH-1:0] eovf,
                             input int nbits, input logic sof_first, input logic ferr_first,
                             input int stall_after, input int stall_len);
        for (int i = 0; i < nbits; i++) begin
            logic [N_CH-1:0] xb;
            logic [N_CH-1:0] yb;
            beat_t e;
            for (int c = 0; c < N_CH; c++) begin
                xb[c] = xw[c][i];
                yb[c] = ew[c][i];
            end
            e.y    = yb;
            e.sof  = (i == 0);
            e.eof  = (i == W - 1);
            e.ovf  = (i == W - 1) ? eovf : {N_CH{1'b0}};
            e.ferr = (i == 0) && ferr_first;
            exp_q.push_back(e);
            put(1'b1, (i == 0) && sof_first, xb, nb);
            if (i == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    put(1'b0, 1'b0, {N_CH{1'b0}}, nb);
                    check("stall_valid", 32'(bus.out_valid), 32'(1'b0));
                    check("stall_y_hold", 32'(bus.y), 32'(yb));
                    check("stall_flags", 32'({bus.out_sof, bus.out_eof, bus.ovf, bus.framing_err}), 32'(0));
                end
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.x        = {N_CH{1'b0}};
        bus.neg      = {N_CH{1'b0}};
        #12;
        check("reset_outputs", 32'({bus.y, bus.out_valid, bus.out_sof, bus.out_eof, bus.ovf, bus.framing_err}), 32'(0));
        r = 1'b1;

        // 1: ch0 0x06 negated -> 0xFA; ch1 pass; ch2 0x7F negated -> 0x81; ch3 zero pass
        send_word({8'h00, 8'h7F, 8'h06, 8'h06}, {8'h00, 8'h81, 8'h06, 8'hFA},
                  4'b0101, 4'b0000, W, 1'b1, 1'b0, -1, 0);
        // 2: 0x80 everywhere, negated on ch0/ch2 -> overflow there (tiled, no sof)
        send_word({8'h80, 8'h80, 8'h80, 8'h80}, {8'h80, 8'h80, 8'h80, 8'h80},
                  4'b0101, 4'b0101, W, 1'b0, 1'b0, -1, 0);
        // 3: edge values 0x00->0x00, 0xFF->0x01, 0x01->0xFF, 0x01 pass
        send_word({8'h01, 8'h01, 8'hFF, 8'h00}, {8'h01, 8'hFF, 8'h01, 8'h00},
                  4'b0111, 4'b0000, W, 1'b0, 1'b0, -1, 0);
        idle(2);
        // 4: stall 3 cycles after bit 3
        send_word({8'h06, 8'h06, 8'h06, 8'h06}, {8'hFA, 8'hFA, 8'hFA, 8'hFA},
                  4'b1111, 4'b0000, W, 1'b0, 1'b0, 3, 3);
        idle(1);
        // 5: five bits of a word, then resync into a full 0x06 word
        send_word({8'h06, 8'h06, 8'h06, 8'h06}, {8'hFA, 8'hFA, 8'hFA, 8'hFA},
                  4'b1111, 4'b0000, 5, 1'b1, 1'b0, -1, 0);
        send_word({8'h06, 8'h06, 8'h06, 8'h06}, {8'hFA, 8'hFA, 8'hFA, 8'hFA},
                  4'b1111, 4'b0000, W, 1'b1, 1'b1, -1, 0);
        // 6: async reset mid-word, between clock edges
        send_word({8'h06, 8'h06, 8'h06, 8'h06}, {8'hFA, 8'hFA, 8'hFA, 8'hFA},
                  4'b1111, 4'b0000, 4, 1'b0, 1'b0, -1, 0);
        @(negedge t_clock);
        #2;
        r = 1'b0;
        #1;
        check("async_reset_now", 32'({bus.y, bus.out_valid, bus.out_sof, bus.out_eof, bus.ovf, bus.framing_err}), 32'(0));
        bus.in_valid = 1'b0;
        @(posedge t_clock);
        #1;
        check("async_reset_held", 32'({bus.y, bus.out_valid, bus.out_sof, bus.out_eof, bus.ovf, bus.framing_err}), 32'(0));
        #2;
        r = 1'b1;
        send_word({8'h80, 8'h03, 8'h03, 8'h03}, {8'h80, 8'hFD, 8'h03, 8'hFD},
                  4'b1101, 4'b1000, W, 1'b0, 1'b0, -1, 0);
        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_twos_comp_mc.md
Name: serial_twos_comp_mc

Overview:
- Multi-channel, bit-serial two's-complement negator. Each word is W bits, sent LSB-first.
- Each channel negates or passes its word, chosen per word.
- Flags overflow when the most-negative value is negated.
- Successor to the single-channel serial inverter: adds parametrised width and channel count, a valid/stall handshake, word framing with resync, and registered status outputs.

Parameters:
- N_CH, 4, number of parallel serial channels sharing one bit clock and one framing.
- W, 8, word length in bits (W >= 2).
- CNT_W, $clog2(W), bit-counter width (derived; do not override).

Ports:
- t_clock  in  1  bit clock; all state updates on rising edge.
- r  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  current bit on x is valid.
- in_sof  in  1  current bit is bit 0 of a word; qualified by in_valid.
- x  in  N_CH  serial input bit, one per channel, LSB-first.
- neg  in  N_CH  per-channel mode: 1 = negate, 0 = pass. Sampled only on bit 0 of a word.
- y  out  N_CH  serial result bits.
- out_valid  out  1  y is valid this cycle.
- out_sof  out  1  y carries bit 0 of a word.
- out_eof  out  1  y carries bit W-1 of a word.
- ovf  out  N_CH  overflow flag, valid only when out_eof=1.
- framing_err  out  1  one-cycle pulse when a word was aborted by a resync.

Behaviour:
- Reset (r=0, async): all of the following clear to 0 immediately, regardless of clock:
  - outputs: y, out_valid, out_sof, out_eof, ovf, framing_err;
  - internal state: bit counter, per-channel seen_one flags, latched mode bits.
- All outputs are registered. Latency is exactly 1 cycle from an accepted input bit to its output bit.
- Input bit accepted when in_valid=1. Counter, flags and mode advance only on accepted bits.
- Bit-0 condition: bit counter = 0, or in_sof=1.
- On an accepted bit-0:
  - mode[c] <= neg[c];
  - seen_one is treated as 0 for this bit.
- Per channel c, on each accepted bit, with m = mode in effect for this word (neg[c] itself on bit 0):
  - y[c] <= x[c] XOR (m AND seen_one[c]);
  - seen_one[c] <= seen_one[c] OR x[c].
- Result: copy bits up to and including the first 1, invert all later bits. This equals the W-bit two's complement, mod 2^W.
- Counter advances 0..W-1. At W-1 it wraps to 0 and clears every seen_one.
- out_sof <= accepted bit had index 0.
- out_eof <= accepted bit had index W-1.
- ovf[c] <= (index W-1) AND m AND x[c] AND NOT seen_one[c]. This marks input 100..0 (-2^(W-1)) negated, which returns itself. In pass mode ovf is always 0.
- Stall (in_valid=0):
  - out_valid, out_sof, out_eof, ovf, framing_err <= 0 next cycle;
  - y holds its last value;
  - counter, seen_one and mode hold.
- Stalls may occur on any bit and for any length.
- Resync: accepted in_sof=1 while counter != 0:
  - the partial word is discarded; no out_eof or ovf is emitted for it;
  - framing_err <= 1 for one cycle;
  - the current bit is processed as bit 0 of a new word (out_sof=1, counter <= 1).
- in_sof=1 with counter=0: normal bit 0, no error.
- in_sof is optional; with in_valid=1 and no sof, words tile back-to-back every W accepted bits.
- in_sof with in_valid=0: ignored.
- Zero word: output all zeros in both modes, ovf=0.
- Channels are fully independent except for the shared counter and handshake. Mixed neg per channel is legal.
- Reset mid-word: the next accepted bit after r returns to 1 is bit 0 of a new word.

Test Plan:
1. Negate 0x06, W=8, ch0, neg=1, x=0,1,1,0,0,0,0,0 (LSB-first) → y=0,1,0,1,1,1,1,1 (0xFA) one cycle later. out_sof on first output bit, out_eof on last, ovf[0]=0.
2. Mixed modes, 0x80 on all channels, neg=4'b0101 → ch0/ch2 y=0x80 with ovf=1 at eof; ch1/ch3 y=0x80 with ovf=0.
3. Edge values: 0x00 with neg=1 → 0x00, ovf=0. 0xFF with neg=1 → 0x01, ovf=0. 0x01 with neg=1 → 0xFF.
4. Mid-word stall: same word as scenario 1 with in_valid=0 for 3 cycles after bit 3 → identical 0xFA, out_valid=0 for exactly those 3 cycles, y held.
5. Resync: in_sof=1 at bit 5 of a word, followed by a full 0x06 word, neg=1 → framing_err pulses once, no eof for the aborted word, new word gives 0xFA.
6. Async reset: r=0 between clock edges at bit 4 → all outputs 0 immediately. After release, 0x03 with neg=1 → 0xFD, with out_sof on the first accepted bit.
